uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver, directly downstream of the baud rate generator; consumes its 16x-oversample tick `rx_en`.
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each bit at mid-bit and presents a parallel byte with a one-cycle done strobe and a framing-error flag.
- Feeds the user/host logic that consumes received bytes.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- OVERSAMPLE, 16, `rx_en` ticks per bit period.

Ports:
- clk  input  1  system clock; sole clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- rx_en  input  1  oversample tick from the baud generator; one clk wide; all state advances only on cycles with rx_en=1.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last completed frame payload; held until the next frame completes.
- rx_done  output  1  one-clk pulse per completed frame, good or bad.
- frame_err  output  1  1 if the last completed frame's stop bit sampled low; updated only at frame completion.
- busy  output  1  high in START, DATA and STOP states.

Behaviour:
- Reset (async, rst_n=0):
  - data_out=0, rx_done=0, frame_err=0, busy=0.
  - State=IDLE; tick_cnt=0, bit_cnt=0, shift register=0.
  - Both synchroniser flops=1 (line idle).
- Input path: rx passes through a 2-flop synchroniser (rx_s). Latency is 2 clk; the FSM uses rx_s only.
- Counters: tick_cnt is 4 bits (0..OVERSAMPLE-1); bit_cnt is 3 bits (0..DATA_BITS-1). Both wrap only under explicit FSM control.
- IDLE:
  - On a tick with rx_s=0: go to START, tick_cnt=0.
- START:
  - On a tick with tick_cnt≠7: tick_cnt++.
  - On a tick with tick_cnt=7 (mid start bit):
    - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rx_s=1: glitch; return to IDLE with no output activity.
- DATA:
  - On a tick with tick_cnt≠15: tick_cnt++.
  - On a tick with tick_cnt=15 (mid data bit):
    - Shift rx_s into the MSB of the shift register (LSB-first reception); tick_cnt=0.
    - If bit_cnt=DATA_BITS-1, go to STOP; else bit_cnt++.
- STOP:
  - On a tick with tick_cnt=15 (mid stop bit):
    - data_out<=shift register.
    - rx_done<=1 for exactly one clk.
    - frame_err<=~rx_s.
    - Next state: IDLE if rx_s=1, else BREAK.
- BREAK (line held low after a bad stop bit):
  - Wait; on a tick with rx_s=1, go to IDLE.
  - Prevents a stuck-low line re-triggering frames.
- rx_done is registered: it rises in the clk after the sampling tick and deasserts the following clk whether or not rx_en is present.
- Back-to-back frames: leaving STOP directly to IDLE lets a start edge arriving at the next tick be accepted. No idle gap is required.
- rx_en=0 for any duration: FSM, counters and outputs frozen; rx_done stays 0.
- Reset mid-frame: frame discarded; no rx_done; outputs return to reset values immediately.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - DATA_BITS and OVERSAMPLE defaults.
  - MID_TICK=OVERSAMPLE/2-1 and LAST_TICK=OVERSAMPLE-1 constants.
- Sub-module bit_sync: 2-flop synchroniser with async active-low reset to 1; reusable by other UART inputs.

Test Plan:
- Reset: assert rst_n mid-way through data bit 3 of frame 0x5A -> all outputs 0 at once, no rx_done. After release, frame 0x81 -> data_out=0x81, rx_done single pulse.
- Nominal: rx_en every 4 clk (64 clk/bit), send 0xA5 8N1 -> exactly one rx_done pulse ~2 clk after the stop-bit mid tick; data_out=0xA5; frame_err=0; busy high from start detection until the pulse.
- Glitch: rx low for 5 ticks, then high -> busy high then low at the tick-7 check; no rx_done; data_out unchanged.
- Framing error: send 0x3C with stop bit low, hold rx low 40 more ticks, then high -> one rx_done, data_out=0x3C, frame_err=1, no further pulse while low. Next frame 0x55 -> data_out=0x55, frame_err=0.
- Back-to-back: 0x00 then 0xFF with the start bit immediately after a single stop bit -> two rx_done pulses 160 ticks apart; data_out 0x00 then 0xFF; frame_err=0 both.
- Tick starvation: hold rx_en=0 for 1000 clk mid-frame while rx toggles -> no state change, no rx_done. Resume ticks with a consistent line -> frame completes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame defaults
// and the oversample tick positions used for mid-bit sampling.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // Tick index at the middle of the start bit, counted from start detection.
  function automatic int mid_tick(input int oversample);
    return oversample / 2 - 1;
  endfunction

  // Tick index one full bit period after the previous sample point.
  function automatic int last_tick(input int oversample);
    return oversample - 1;
  endfunction

  localparam int MID_TICK  = mid_tick(OVERSAMPLE_DEF);
  localparam int LAST_TICK = last_tick(OVERSAMPLE_DEF);

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Resets to RESET_VAL so an idle-high serial line reads as idle.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample tick; samples each bit at
// mid-bit and reports every completed frame with a one-clk done strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW    = $clog2(OVERSAMPLE);
  localparam int BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int T_MID = mid_tick(OVERSAMPLE);
  localparam int T_END = last_tick(OVERSAMPLE);

  logic rx_s;

  state_t                state_reg, state_next;
  logic [TW-1:0]         tick_reg, tick_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic [DATA_BITS-1:0]  data_reg, data_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    err_next   = err_reg;

    if (rx_en) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_reg == TW'(T_MID)) begin
            if (!rx_s) begin
              state_next = DATA;
              tick_next  = '0;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        DATA: begin
          if (tick_reg == TW'(T_END)) begin
            // LSB arrives first, so it ends up at bit 0 after the last shift.
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            tick_next  = '0;
            if (bit_reg == BW'(DATA_BITS - 1)) begin
              state_next = STOP;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        STOP: begin
          if (tick_reg == TW'(T_END)) begin
            data_next  = shift_reg;
            done_next  = 1'b1;
            err_next   = ~rx_s;
            tick_next  = '0;
            state_next = rx_s ? IDLE : BREAK;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        BREAK: begin
          // A line stuck low must return high before a new start is accepted.
          if (rx_s) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_reg;
  assign rx_done   = done_reg;
  assign frame_err = err_reg;
  assign busy      = (state_reg == START) || (state_reg == DATA) ||
                     (state_reg == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are built at bit level and
// each reported byte is compared against the byte that was sent.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx_en;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic       tick_on;
  logic [1:0] div;
  int         tick_count = 0;

  int         done_cnt = 0;
  int         wide_cnt = 0;
  logic       prev_done = 1'b0;
  logic [7:0] last_data;
  logic       last_err;
  int         last_tick;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_en     (rx_en),
    .rx        (rx),
    .data_out  (data_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick every 4 clk while tick_on is set.
  initial begin
    rx_en = 1'b0;
    div   = 2'd0;
    forever begin
      @(negedge clk);
      div   = div + 2'd1;
      rx_en = tick_on && (div == 2'd0);
    end
  end

  always @(posedge clk) if (rx_en) tick_count <= tick_count + 1;

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      last_data = data_out;
      last_err  = frame_err;
      last_tick = tick_count;
      if (prev_done === 1'b1) wide_cnt = wide_cnt + 1;
    end
    prev_done = rx_done;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish (done_cnt=%0d)", done_cnt);
    $fatal(1, "timeout");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (rx_en !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  function automatic logic [9:0] mk(input logic [7:0] b, input logic stop);
    return {stop, b, 1'b0};
  endfunction

  // Drive frame ticks [t0, t1); each bit lasts 16 ticks, bit 0 is the start bit.
  task automatic drive_frame(input logic [9:0] f, input int t0, input int t1);
    for (int t = t0; t < t1; t++) begin
      rx = f[t/16];
      wait_ticks(1);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    if ({data_out, rx_done, frame_err, busy} !== 11'd0) begin
      $display("FAIL reset_outputs: got data=%h done=%b err=%b busy=%b want all 0",
               data_out, rx_done, frame_err, busy);
      failures++;
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);
    if (busy !== 1'b0 || done_cnt !== 0) begin
      $display("FAIL reset_idle: got busy=%b pulses=%0d want 0 0", busy, done_cnt);
      failures++;
    end
    checks++;
  endtask

  task automatic test_nominal;
    int c0, k;
    c0 = done_cnt;
    k  = tick_count;
    rx = 1'b0;
    wait_ticks(3);
    if (busy !== 1'b1) begin
      $display("FAIL nominal_busy_start: got %b want 1", busy);
      failures++;
    end
    checks++;
    drive_frame(mk(8'hA5, 1'b1), 3, 160);
    if (done_cnt - c0 !== 1 || last_data !== 8'hA5 || last_err !== 1'b0) begin
      $display("FAIL nominal_frame: got pulses=%0d data=%h err=%b want 1 a5 0",
               done_cnt - c0, last_data, last_err);
      failures++;
    end
    checks++;
    // Start seen 1 tick after the edge, mid-start 8 ticks later, 9 more bit periods.
    if (last_tick - k !== 153) begin
      $display("FAIL nominal_timing: got pulse at tick %0d want 153", last_tick - k);
      failures++;
    end
    checks++;
    if (busy !== 1'b0 || data_out !== 8'hA5) begin
      $display("FAIL nominal_hold: got busy=%b data=%h want 0 a5", busy, data_out);
      failures++;
    end
    checks++;
  endtask

  task automatic test_reset_midframe;
    int c0;
    c0 = done_cnt;
    drive_frame(mk(8'h5A, 1'b1), 0, 72);
    #2;
    rst_n = 1'b0;
    #1;
    if ({data_out, rx_done, frame_err, busy} !== 11'd0) begin
      $display("FAIL midreset_outputs: got data=%h done=%b err=%b busy=%b want all 0",
               data_out, rx_done, frame_err, busy);
      failures++;
    end
    checks++;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(30);
    if (done_cnt !== c0) begin
      $display("FAIL midreset_no_done: got pulses=%0d want 0", done_cnt - c0);
      failures++;
    end
    checks++;
    drive_frame(mk(8'h81, 1'b1), 0, 160);
    if (done_cnt - c0 !== 1 || last_data !== 8'h81 || last_err !== 1'b0) begin
      $display("FAIL midreset_next: got pulses=%0d data=%h err=%b want 1 81 0",
               done_cnt - c0, last_data, last_err);
      failures++;
    end
    checks++;
  endtask

  task automatic test_glitch;
    int c0;
    logic [7:0] d0;
    c0 = done_cnt;
    d0 = data_out;
    rx = 1'b0;
    wait_ticks(3);
    if (busy !== 1'b1) begin
      $display("FAIL glitch_busy: got %b want 1", busy);
      failures++;
    end
    checks++;
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(8);
    if (busy !== 1'b0 || done_cnt !== c0 || data_out !== d0) begin
      $display("FAIL glitch_reject: got busy=%b pulses=%0d data=%h want 0 0 %h",
               busy, done_cnt - c0, data_out, d0);
      failures++;
    end
    checks++;
    wait_ticks(20);
  endtask

  task automatic test_frame_err;
    int c0;
    c0 = done_cnt;
    drive_frame(mk(8'h3C, 1'b0), 0, 160);
    rx = 1'b0;
    wait_ticks(40);
    if (done_cnt - c0 !== 1 || last_data !== 8'h3C || frame_err !== 1'b1) begin
      $display("FAIL ferr_frame: got pulses=%0d data=%h err=%b want 1 3c 1",
               done_cnt - c0, last_data, frame_err);
      failures++;
    end
    checks++;
    rx = 1'b1;
    wait_ticks(20);
    if (done_cnt - c0 !== 1 || busy !== 1'b0) begin
      $display("FAIL ferr_break: got pulses=%0d busy=%b want 1 0", done_cnt - c0, busy);
      failures++;
    end
    checks++;
    drive_frame(mk(8'h55, 1'b1), 0, 160);
    if (done_cnt - c0 !== 2 || last_data !== 8'h55 || frame_err !== 1'b0) begin
      $display("FAIL ferr_recover: got pulses=%0d data=%h err=%b want 2 55 0",
               done_cnt - c0, last_data, frame_err);
      failures++;
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    int c0, t0;
    logic e0;
    c0 = done_cnt;
    drive_frame(mk(8'h00, 1'b1), 0, 160);
    t0 = last_tick;
    e0 = last_err;
    if (done_cnt - c0 !== 1 || last_data !== 8'h00 || e0 !== 1'b0) begin
      $display("FAIL b2b_first: got pulses=%0d data=%h err=%b want 1 00 0",
               done_cnt - c0, last_data, e0);
      failures++;
    end
    checks++;
    drive_frame(mk(8'hFF, 1'b1), 0, 160);
    if (done_cnt - c0 !== 2 || last_data !== 8'hFF || last_err !== 1'b0) begin
      $display("FAIL b2b_second: got pulses=%0d data=%h err=%b want 2 ff 0",
               done_cnt - c0, last_data, last_err);
      failures++;
    end
    checks++;
    if (last_tick - t0 !== 160) begin
      $display("FAIL b2b_spacing: got %0d ticks want 160", last_tick - t0);
      failures++;
    end
    checks++;
  endtask

  task automatic test_starvation;
    int c0;
    logic [9:0] f;
    c0 = done_cnt;
    f  = mk(8'h96, 1'b1);
    drive_frame(f, 0, 72);
    rx = f[4];
    tick_on = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      rx = 1'($urandom_range(0, 1));
    end
    if (busy !== 1'b1 || done_cnt !== c0 || rx_done !== 1'b0) begin
      $display("FAIL starve_frozen: got busy=%b pulses=%0d done=%b want 1 0 0",
               busy, done_cnt - c0, rx_done);
      failures++;
    end
    checks++;
    rx = f[4];
    repeat (4) @(negedge clk);
    tick_on = 1'b1;
    drive_frame(f, 72, 160);
    if (done_cnt - c0 !== 1 || last_data !== 8'h96 || last_err !== 1'b0) begin
      $display("FAIL starve_resume: got pulses=%0d data=%h err=%b want 1 96 0",
               done_cnt - c0, last_data, last_err);
      failures++;
    end
    checks++;
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b, want;
    int c0;
    for (int i = 0; i < 8; i++) begin
      c0 = done_cnt;
      b  = 8'($urandom);
      exp_q.push_back(b);
      wait_ticks($urandom_range(0, 30));
      drive_frame(mk(b, 1'b1), 0, 160);
      want = exp_q.pop_front();
      if (done_cnt - c0 !== 1 || last_data !== want || last_err !== 1'b0) begin
        $display("FAIL random_%0d: got pulses=%0d data=%h err=%b want 1 %h 0",
                 i, done_cnt - c0, last_data, last_err, want);
        failures++;
      end
      checks++;
    end
  endtask

  task automatic test_pulse_width;
    if (wide_cnt !== 0) begin
      $display("FAIL done_width: got %0d multi-cycle pulses want 0", wide_cnt);
      failures++;
    end
    checks++;
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    tick_on = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_nominal();
    test_reset_midframe();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_starvation();
    test_random();
    test_pulse_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
